disc_layer3_scheduler: RTL and testbench

Schedules the discriminator output layer (`layer3_discriminator`: 32×Q8.8 in → Q8.8 score plus real/fake decision) as a single shared resource for two requesters. Port 0 carries real-image features and port 1 carries generator-image features.
- Round-robin arbitration between the two ports.
- Latches the winning 32-element vector and holds it stable for the layer.
- Pulses `l3_start`, waits for `l3_done` under a timeout watchdog.
- Returns the tagged result on a valid/ready output channel.
- Sits between discriminator layer 2 and the GAN training/score collector.

---
 rtl/gan_disc_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 20 ++
 rtl/disc_layer3_scheduler.sv | 153 +++++++++++++++
 tb/tb_disc_layer3_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gan_disc_pkg.sv
// Shared types and constants for the GAN discriminator blocks.
package gan_disc_pkg;

  // Element / score width (signed Q8.8) and output-layer fan-in.
  localparam int Q88_W        = 16;
  localparam int DISC_L3_N_IN = 32;

  // Source indices on the layer-3 scheduler request ports.
  localparam logic SRC_REAL = 1'b0;
  localparam logic SRC_FAKE = 1'b1;

  // Layer-3 scheduler control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } l3_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. When both sources request, the source that
// was not granted last time wins. Purely combinational.
module rr_arbiter2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant from the current requests and the previous winner.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/disc_layer3_scheduler.sv
// Shares one discriminator output layer between the real-image path (src 0)
// and the generator-image path (src 1). A request is accepted only in IDLE;
// the vector is latched and held for the layer, the layer is started with a
// single pulse, and its result (or a watchdog timeout) is offered on a
// valid/ready channel.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is a combinational function of state and the
// arbiter grant only (never of req_data); res_valid, once high, stays high
// with all res_* stable until the edge where res_ready is seen high.
module disc_layer3_scheduler
  import gan_disc_pkg::*;
#(
  parameter int N_IN    = DISC_L3_N_IN,
  parameter int DW      = Q88_W,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [N_IN*DW-1:0]   req_data0_flat,
  input  logic [N_IN*DW-1:0]   req_data1_flat,
  output logic                 l3_start,
  output logic [N_IN*DW-1:0]   l3_flat_input_flat,
  input  logic [DW-1:0]        l3_score_out,
  input  logic                 l3_decision_real,
  input  logic                 l3_done,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DW-1:0]        res_score,
  output logic                 res_decision,
  output logic                 res_src,
  output logic                 res_timeout,
  output logic                 busy,
  output logic [CNT_W-1:0]     real_cnt,
  output logic [CNT_W-1:0]     fake_cnt
);

  // Watchdog wide enough to hold TIMEOUT-1; TIMEOUT must be at least 2.
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  // Expiry fires on the WAIT cycle whose increment would reach TIMEOUT-1,
  // which puts res_valid exactly TIMEOUT cycles after l3_start.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

  l3_state_e        state;
  l3_state_e        state_next;
  logic             last_grant;
  logic [1:0]       grant;
  logic             accept;
  logic             accept_src;
  logic [WD_W-1:0]  wd_cnt;
  logic             wd_expire;
  logic             res_fire;

  rr_arbiter2 u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept     = (state == ST_IDLE) && ((req_valid & grant) != 2'b00);
  assign accept_src = grant[1] ? SRC_FAKE : SRC_REAL;
  assign wd_expire  = (state == ST_WAIT) && !l3_done && (wd_cnt == WD_LAST);
  assign res_fire   = res_valid && res_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; l3_done is only looked at in WAIT.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_LAUNCH;
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT:   if (l3_done || wd_expire) state_next = ST_HOLD;
      ST_HOLD:   if (res_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs; all drop together with an async reset.
  always_comb begin
    req_ready = 2'b00;
    l3_start  = 1'b0;
    res_valid = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE:   req_ready = grant;
      ST_LAUNCH: l3_start  = 1'b1;
      ST_HOLD:   res_valid = 1'b1;
      default:   ;
    endcase
  end

  // Latch the winning vector, its source tag and the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l3_flat_input_flat <= '0;
      res_src            <= 1'b0;
      last_grant         <= 1'b1;
    end else if (accept) begin
      l3_flat_input_flat <= accept_src ? req_data1_flat : req_data0_flat;
      res_src            <= accept_src;
      last_grant         <= accept_src;
    end
  end

  // Watchdog: cleared while launching, counts every WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     wd_cnt <= '0;
    else if (state == ST_LAUNCH) wd_cnt <= '0;
    else if (state == ST_WAIT)   wd_cnt <= wd_cnt + 1'b1;
  end

  // Capture the layer result, or a zero result flagged as timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_score    <= '0;
      res_decision <= 1'b0;
      res_timeout  <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (l3_done) begin
        res_score    <= l3_score_out;
        res_decision <= l3_decision_real;
        res_timeout  <= 1'b0;
      end else if (wd_expire) begin
        res_score    <= '0;
        res_decision <= 1'b0;
        res_timeout  <= 1'b1;
      end
    end
  end

  // Saturating real/fake tallies, updated on each delivered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      real_cnt <= '0;
      fake_cnt <= '0;
    end else if (res_fire) begin
      if (res_decision) begin
        if (real_cnt != {CNT_W{1'b1}}) real_cnt <= real_cnt + 1'b1;
      end else begin
        if (fake_cnt != {CNT_W{1'b1}}) fake_cnt <= fake_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disc_layer3_scheduler.sv
// Directed bench for disc_layer3_scheduler with a stub output layer that
// answers 8 cycles after l3_start with score = element 0 of the vector.
module tb_disc_layer3_scheduler;

  localparam int N_IN    = 32;
  localparam int DW      = 16;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [N_IN*DW-1:0]   req_data0_flat;
  logic [N_IN*DW-1:0]   req_data1_flat;
  logic                 l3_start;
  logic [N_IN*DW-1:0]   l3_flat_input_flat;
  logic [DW-1:0]        l3_score_out = '0;
  logic                 l3_decision_real = 1'b0;
  logic                 l3_done;
  logic                 res_valid;
  logic                 res_ready;
  logic [DW-1:0]        res_score;
  logic                 res_decision;
  logic                 res_src;
  logic                 res_timeout;
  logic                 busy;
  logic [CNT_W-1:0]     real_cnt;
  logic [CNT_W-1:0]     fake_cnt;

  int   total = 0;
  int   bad   = 0;
  int   n;
  int   starts;
  int   stub_cnt = 0;
  logic stub_done = 1'b0;
  logic stub_en;
  logic force_done;
  logic both_seen = 1'b0;

  // Clock.
  always #5 clk = ~clk;

  disc_layer3_scheduler #(
    .N_IN(N_IN), .DW(DW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_data0_flat     (req_data0_flat),
    .req_data1_flat     (req_data1_flat),
    .l3_start           (l3_start),
    .l3_flat_input_flat (l3_flat_input_flat),
    .l3_score_out       (l3_score_out),
    .l3_decision_real   (l3_decision_real),
    .l3_done            (l3_done),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_score          (res_score),
    .res_decision       (res_decision),
    .res_src            (res_src),
    .res_timeout        (res_timeout),
    .busy               (busy),
    .real_cnt           (real_cnt),
    .fake_cnt           (fake_cnt)
  );

  assign l3_done = stub_done | force_done;

  // Stub layer: start seen in cycle A, done high during cycle A+8.
  always @(negedge clk) begin
    if (rst) begin
      stub_cnt  = 0;
      stub_done = 1'b0;
    end else if (l3_start) begin
      stub_cnt  = 1;
      stub_done = 1'b0;
    end else if (stub_cnt != 0) begin
      stub_cnt = stub_cnt + 1;
      if (stub_cnt == 9) begin
        stub_done        = stub_en;
        l3_score_out     = l3_flat_input_flat[DW-1:0];
        l3_decision_real = ($signed(l3_flat_input_flat[DW-1:0]) > 0);
      end else begin
        stub_done = 1'b0;
        if (stub_cnt >= 10) stub_cnt = 0;
      end
    end
  end

  // Remember whether both request ports were ever granted together.
  always @(negedge clk) begin
    if (req_ready == 2'b11) both_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_res(input int maxc, output int cyc);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < maxc) begin
      tick();
      cyc++;
    end
  endtask

  function automatic logic [N_IN*DW-1:0] mk_vec(input logic [DW-1:0] v);
    logic [N_IN*DW-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  initial begin
    rst = 1'b1; req_valid = 2'b00; res_ready = 1'b0;
    req_data0_flat = '0; req_data1_flat = '0;
    force_done = 1'b0; stub_en = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_l3_start", l3_start, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_real_cnt", real_cnt, 0);
    chk("rst_fake_cnt", fake_cnt, 0);
    chk("rst_res_score", res_score, 0);
    chk("rst_flat_zero", l3_flat_input_flat === '0, 1);
    rst = 1'b0;
    tick();

    // Contention: source 0 first after reset, then source 1.
    req_data0_flat = mk_vec(16'd100);
    req_data1_flat = mk_vec(16'hFF9C); // -100
    req_valid = 2'b11;
    res_ready = 1'b1;
    #1;
    chk("c_grant_first", req_ready, 2'b01);
    tick();
    chk("c0_start", l3_start, 1);
    chk("c0_src", res_src, 0);
    wait_res(40, n);
    chk("c0_valid", res_valid, 1);
    chk("c0_score", res_score, 16'd100);
    chk("c0_src_hold", res_src, 0);
    tick();
    chk("c_grant_second", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("c1_src", res_src, 1);
    wait_res(40, n);
    chk("c1_valid", res_valid, 1);
    chk("c1_score", res_score, 16'hFF9C);
    chk("c1_decision", res_decision, 0);
    tick();
    chk("c_real_cnt", real_cnt, 1);
    chk("c_fake_cnt", fake_cnt, 1);
    chk("c_never_both", both_seen, 0);

    // Single request from source 0, latency check.
    req_data0_flat = mk_vec(16'd50);
    req_valid = 2'b01;
    #1;
    chk("t1_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("t1_start", l3_start, 1);
    chk("t1_flat", l3_flat_input_flat === mk_vec(16'd50), 1);
    n = 1;
    starts = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (l3_start) starts++;
    end
    chk("t1_latency", n, 10);
    chk("t1_one_start", starts, 0);
    chk("t1_score", res_score, 16'd50);
    chk("t1_src", res_src, 0);
    chk("t1_timeout", res_timeout, 0);
    chk("t1_decision", res_decision, 1);
    tick();
    chk("t1_real_cnt", real_cnt, 2);

    // Backpressure: result held for 20 cycles, requests blocked.
    res_ready = 1'b0;
    req_data1_flat = mk_vec(16'd300);
    req_valid = 2'b10;
    #1;
    chk("bp_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b11;
    req_data1_flat = mk_vec(16'd1);
    wait_res(40, n);
    chk("bp_valid", res_valid, 1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold",
          {res_valid, busy, req_ready, res_src, res_decision, res_timeout, res_score},
          {1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 16'd300});
      chk("bp_flat", l3_flat_input_flat === mk_vec(16'd300), 1);
      force_done = (i == 5);
      req_data0_flat[DW-1:0] = DW'($urandom);
      tick();
    end
    force_done = 1'b0;
    req_valid = 2'b00;
    res_ready = 1'b1;
    tick();
    chk("bp_released", res_valid, 0);
    chk("bp_real_cnt", real_cnt, 3);
    tick();
    chk("bp_real_once", real_cnt, 3);
    chk("bp_idle", busy, 0);

    // Timeout: stub stays silent.
    res_ready = 1'b0;
    stub_en = 1'b0;
    req_data0_flat = mk_vec(16'd77);
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    chk("to_start", l3_start, 1);
    n = 1;
    while (res_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("to_latency", n, 65);
    chk("to_flag", res_timeout, 1);
    chk("to_score", res_score, 0);
    chk("to_decision", res_decision, 0);
    chk("to_src", res_src, 0);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    chk("to_late_hold", {res_valid, res_timeout, res_score}, {1'b1, 1'b1, 16'd0});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("to_fake_cnt", fake_cnt, 2);
    chk("to_real_cnt", real_cnt, 3);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    chk("to_late_idle", {busy, res_valid}, 2'b00);
    tick();
    chk("to_no_start", l3_start, 0);
    chk("to_fake_still", fake_cnt, 2);
    stub_en = 1'b1;

    // Reset while waiting for the layer.
    req_data1_flat = mk_vec(16'd9);
    req_valid = 2'b10;
    #1;
    tick();
    req_valid = 2'b00;
    chk("rw_start", l3_start, 1);
    repeat (3) tick();
    chk("rw_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_l3_start", l3_start, 0);
    chk("rw_res_valid", res_valid, 0);
    chk("rw_counts", {real_cnt, fake_cnt}, 0);
    chk("rw_flat", l3_flat_input_flat === '0, 1);
    tick();
    rst = 1'b0;
    req_data0_flat = mk_vec(16'd11);
    req_data1_flat = mk_vec(16'd12);
    req_valid = 2'b11;
    #1;
    chk("rw_first_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    res_ready = 1'b1;
    wait_res(40, n);
    chk("rw_valid", res_valid, 1);
    chk("rw_score", res_score, 16'd11);
    chk("rw_src", res_src, 0);
    tick();
    chk("rw_real_cnt", real_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
